// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader, write side of the instruction memory.
// Takes a byte stream over valid/ready, assembles big-endian 32-bit words and
// writes them to consecutive word addresses starting at BASE_ADDR. The core is
// held frozen (cpu_hold) until the image has loaded successfully.
//
// Stream: 2-byte word count N (MSB first), 4N data bytes (each word MSB first),
// and, when IMEM_LOADER_CHECKSUM_EN is defined, a 4-byte trailer (MSB first)
// that must equal the 32-bit wrapping sum of all data words.
//
// Parameters:
//   ADDR_W    word-address width; capacity is 2^ADDR_W words
//   BASE_ADDR byte address of word 0 (4-aligned)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle load request (honoured in IDLE/DONE/ERR)
//   in_valid, in_data   byte stream input
//   in_ready            loader accepts a byte this cycle
//   wr_en/addr/data     one-cycle instruction-memory write
//   cpu_hold            pipeline freeze, low only in DONE
//   busy, done, error   load status
// Build option: `define IMEM_LOADER_CHECKSUM_EN enables the trailer check.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN,
    S_DONE,
    S_ERR
  } state_t;

  // N may equal the capacity, so both the limit and the word index need one
  // bit more than a plain word address.
  localparam logic [32:0]   CAP     = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_t            state;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_cnt;
  logic [31:0]       asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum;
  logic [31:0]       trl;
  logic              chk_ok;
`endif

  logic [15:0] hdr_n;
  logic [31:0] word_nxt;
  logic        last_word;

  assign hdr_n     = {n_words[15:8], in_data};
  assign word_nxt  = {asm_q[23:0], in_data};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(n_words);

  // Status flags are pure decodes of the registered state.
  always_comb begin
    in_ready = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state == S_CHK)
`endif
               ;
    busy     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    done     = (state == S_DONE);
    error    = (state == S_ERR);
    cpu_hold = (state != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      n_words  <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
      trl      <= '0;
      chk_ok   <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR_HI;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= '0;
            trl      <= '0;
            chk_ok   <= 1'b0;
`endif
          end
        end
        S_HDR_HI: if (in_valid) begin
          n_words[15:8] <= in_data;
          state         <= S_HDR_LO;
        end
        S_HDR_LO: if (in_valid) begin
          n_words[7:0] <= in_data;
          if (hdr_n == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= S_CHK;
`else
            state <= S_FIN;
`endif
          else if ({17'd0, hdr_n} > CAP)
            state <= S_ERR;
          else
            state <= S_DATA;
        end
        S_DATA: if (in_valid) begin
          asm_q    <= word_nxt;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            wr_en    <= 1'b1;
            wr_addr  <= BASE_ADDR + (32'(word_idx) << 2);
            wr_data  <= word_nxt;
            word_idx <= word_idx + IDX_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + word_nxt;
            if (last_word) state <= S_CHK;
`else
            if (last_word) state <= S_FIN;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // byte_cnt has wrapped back to 0 on leaving DATA, so it counts the
        // trailer bytes too; the verdict is taken while sitting in FIN.
        S_CHK: if (in_valid) begin
          trl      <= {trl[23:0], in_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            chk_ok <= ({trl[23:0], in_data} == sum);
            state  <= S_FIN;
          end
        end
        S_FIN: state <= chk_ok ? S_DONE : S_ERR;
`else
        S_FIN: state <= S_DONE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
